// File: rtl/mmu_pkg.sv
// mmu_pkg: shared defaults and state encoding for the systolic-array MMU controller
package mmu_pkg;
  localparam int DIM_DEF = 16;
  localparam int RES_LAT_DEF = 2 * DIM_DEF - 1;
  localparam int ROWS_W_DEF = 9;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOADW   = 3'd1,
    SETTLE  = 3'd2,
    COMPUTE = 3'd3,
    DONE    = 3'd4
  } state_t;
endpackage

// File: rtl/mmu_phase_cnt.sv
// mmu_phase_cnt: loadable down-counter with freeze and terminal-count flag
module mmu_phase_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         freeze,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);
  // load wins so a new phase can always start; otherwise count toward zero and park there
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!freeze && cnt != '0) cnt <= cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/mmu_ctrl.sv
// mmu_ctrl: sequences weight load, settle and compute phases of a systolic-array job
module mmu_ctrl import mmu_pkg::*; #(
  parameter int DIM = DIM_DEF,
  parameter int RES_LAT = RES_LAT_DEF,
  parameter int ROWS_W = ROWS_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ROWS_W-1:0]        num_rows,
  input  logic                     stall,
  output logic                     busy,
  output logic                     done,
  output logic                     wwrite,
  output logic [$clog2(DIM)-1:0]   w_rd_addr,
  output logic                     active,
  output logic                     d_rd_en,
  output logic [ROWS_W-1:0]        d_rd_addr,
  output logic                     r_wr_en,
  output logic [ROWS_W-1:0]        r_wr_addr
);
  localparam int AW = $clog2(DIM);
  localparam int CW = ROWS_W + 1;
  state_t state, nxt;
  logic [ROWS_W-1:0] rows;
  logic load, tc, adv, rd_win, wr_win;
  logic [CW-1:0] load_val, cnt;
  assign adv = !stall && tc;
  mmu_phase_cnt #(.W(CW)) u_cnt (
    .clk(clk), .rst_n(rst_n), .load(load), .freeze(stall),
    .load_val(load_val), .cnt(cnt), .tc(tc)
  );
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // job row count captured when a start is accepted
  always_ff @(posedge clk)
    if (!rst_n) rows <= '0;
    else if (state == IDLE && start) rows <= num_rows;
  // phase transitions; the counter is reloaded for each phase that follows
  always_comb begin
    nxt = state;
    load = 1'b0;
    load_val = CW'(DIM - 1);
    unique case (state)
      IDLE: if (start) begin
        nxt = num_rows != '0 ? LOADW : DONE;
        load = 1'b1;
      end
      LOADW: if (adv) begin
        nxt = SETTLE;
        load = 1'b1;
      end
      SETTLE: if (adv) begin
        nxt = COMPUTE;
        load = 1'b1;
        load_val = CW'(rows) + CW'(RES_LAT - 1);
      end
      COMPUTE: if (adv) nxt = DONE;
      DONE: if (!stall) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // outputs; compute cycle c = rows+RES_LAT-1-cnt, so read window is cnt>=RES_LAT and write window cnt<rows
  always_comb begin
    busy = state != IDLE;
    done = state == DONE && !stall;
    wwrite = state == LOADW && !stall;
    w_rd_addr = state == LOADW ? cnt[AW-1:0] : '0;
    active = state == COMPUTE && !stall;
    rd_win = state == COMPUTE && cnt >= CW'(RES_LAT);
    wr_win = state == COMPUTE && cnt < CW'(rows);
    d_rd_en = rd_win && !stall;
    d_rd_addr = rd_win ? ROWS_W'(CW'(rows) + CW'(RES_LAT - 1) - cnt) : '0;
    r_wr_en = wr_win && !stall;
    r_wr_addr = wr_win ? ROWS_W'(CW'(rows) - 1'b1 - cnt) : '0;
  end
endmodule

// File: tb/tb_mmu_ctrl.sv
// tb_mmu_ctrl: directed checks of the MMU controller job timeline
module tb_mmu_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
  logic [8:0] num_rows = '0;
  logic busy, done, wwrite, active, d_rd_en, r_wr_en;
  logic [3:0] w_rd_addr;
  logic [8:0] d_rd_addr, r_wr_addr;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  mmu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .stall(stall),
    .busy(busy), .done(done), .wwrite(wwrite), .w_rd_addr(w_rd_addr), .active(active),
    .d_rd_en(d_rd_en), .d_rd_addr(d_rd_addr), .r_wr_en(r_wr_en), .r_wr_addr(r_wr_addr)
  );
  function automatic logic [27:0] mk(input bit b, input bit d, input bit w, input logic [3:0] wa,
                                     input bit a, input bit de, input logic [8:0] da,
                                     input bit re, input logic [8:0] ra);
    return {b, d, w, wa, a, de, da, re, ra};
  endfunction
  function automatic logic [27:0] msk(input bit wa, input bit da, input bit ra);
    return {3'b111, {4{wa}}, 2'b11, {9{da}}, 1'b1, {9{ra}}};
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [27:0] e, input logic [27:0] m);
    logic [27:0] obs;
    obs = {busy, done, wwrite, w_rd_addr, active, d_rd_en, d_rd_addr, r_wr_en, r_wr_addr};
    total++;
    assert ((obs & m) === (e & m)) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs & m, e & m);
  endtask
  task automatic run_job(input int r, input int sc, input int sl, input bit poke);
    bit in_d, in_r;
    int n;
    start = 1'b1;
    num_rows = r[8:0];
    step;
    start = 1'b0;
    num_rows = 9'h1AA;
    if (r == 0) begin
      chk("zero_done", mk(1, 1, 0, 0, 0, 0, 0, 0, 0), msk(0, 0, 0));
      step;
    end else begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("r%0d_load%0d", r, k), mk(1, 0, 1, 4'(15 - k), 0, 0, 0, 0, 0), msk(1, 0, 0));
        step;
      end
      for (int k = 0; k < 16; k++) begin
        start = poke && k == 3;
        chk($sformatf("r%0d_settle%0d", r, k), mk(1, 0, 0, 0, 0, 0, 0, 0, 0), msk(0, 0, 0));
        step;
        start = 1'b0;
      end
      for (int c = 0; c < r + 31; c++) begin
        n = c == sc ? sl : 0;
        for (int s = 0; s <= n; s++) begin
          stall = s < n;
          #1;
          in_d = c < r;
          in_r = c >= 31 && c < r + 31;
          chk($sformatf("r%0d_comp%0d_s%0d", r, c, s),
              mk(1, 0, 0, 0, !stall, in_d && !stall, 9'(c), in_r && !stall, 9'(c - 31)),
              msk(0, in_d, in_r));
          step;
        end
      end
      stall = 1'b0;
      chk($sformatf("r%0d_done", r), mk(1, 1, 0, 0, 0, 0, 0, 0, 0), msk(0, 0, 0));
      step;
    end
    chk($sformatf("r%0d_idle", r), mk(0, 0, 0, 0, 0, 0, 0, 0, 0), msk(0, 0, 0));
  endtask
  initial begin
    step;
    step;
    chk("reset", '0, msk(1, 1, 1));
    rst_n = 1'b1;
    step;
    chk("post_reset_idle", '0, msk(1, 1, 1));
    run_job(4, -1, 0, 1'b0);
    run_job(0, -1, 0, 1'b0);
    step;
    chk("zero_no_rerun", '0, msk(0, 0, 0));
    run_job(4, 2, 3, 1'b0);
    run_job(5, -1, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("poke_idle%0d", i), '0, msk(0, 0, 0));
    end
    start = 1'b1;
    num_rows = 9'd4;
    step;
    start = 1'b0;
    repeat (5) step;
    chk("mid_load5", mk(1, 0, 1, 4'd10, 0, 0, 0, 0, 0), msk(1, 0, 0));
    rst_n = 1'b0;
    step;
    chk("mid_reset", '0, msk(1, 1, 1));
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      step;
      chk($sformatf("abandon%0d", i), '0, msk(0, 0, 0));
    end
    run_job(4, -1, 0, 1'b0);
    run_job(256, -1, 0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
